period_meter: RTL
=================

# period_meter

Measures the spacing, in `clk` cycles, between successive rising edges of a strobe input. It receives divided-clock ticks and similar strobes, and verifies or reports their rate to downstream logic. Each measured period is presented on a valid/ready output. The block also flags a missing strobe (timeout) and flags a measurement dropped because the consumer stalled (overrun).

## Interface
- `WIDTH`, 32: width of the period counter and result; `TIMEOUT` must be < 2^WIDTH.
- `TIMEOUT`, 1_000_000: number of cycles without an edge before the measurement is abandoned; must be ≥ 2.
- `clk` input 1: single clock; all logic is in this domain.
- `reset` input 1: asynchronous, active-high reset.
- `tick_in` input 1: strobe under measurement; may be asynchronous to `clk`.
- `period` output WIDTH: last accepted period in cycles; stable while `period_valid` is high.
- `period_valid` output 1: result available; held high until it is accepted.
- `period_ready` input 1: consumer accepts the result when `period_valid && period_ready`.
- `timeout` output 1: one-cycle pulse when no edge has arrived within `TIMEOUT` cycles.
- `overrun` output 1: sticky; a new measurement was dropped because the held result had not been accepted.
- `active` output 1: high while in MEASURE.

## Operation
- Front end: 2-flop synchronizer on `tick_in`, then rising-edge detect (`edge = s & ~s_prev`). A level held high for many cycles counts as one edge. A constant-high input produces one edge and then a timeout.
- States: IDLE and MEASURE.
  - IDLE: `cnt` = 0. On `edge`: go to MEASURE and load `cnt` = 1.
  - MEASURE, `edge`:
    - Capture `cnt` as the new period and load `cnt` = 1.
    - Stay in MEASURE.
  - MEASURE, no edge, `cnt` < TIMEOUT: `cnt` increments by 1.
  - MEASURE, no edge, `cnt` == TIMEOUT:
    - Pulse `timeout`.
    - Go to IDLE with `cnt` = 0.
    - No period is produced.
- Simultaneous edge and `cnt` == TIMEOUT: the edge wins. Period = TIMEOUT, no timeout pulse. `cnt` never exceeds TIMEOUT, so it cannot wrap.
- Result register, on capture:
  - If `period_valid` is low, or is being accepted in the same cycle: load `period` and set `period_valid`.
  - Otherwise: keep the old `period`, discard the new value, and set `overrun`.
- Acceptance with no capture clears `period_valid`. `period` keeps its last value.
- `overrun` clears only on `reset`.
- A timeout does not affect a held result.
- Reset state:
  - State IDLE, `cnt` = 0, synchronizer and `s_prev` = 0.
  - `period` = 0, `period_valid` = 0, `timeout` = 0, `overrun` = 0, `active` = 0.
  - Because `s_prev` resets to 0, a `tick_in` already high at reset release registers as an edge.
- Reset asserted mid-measurement immediately abandons the measurement and any held result.

## Timing
- Edge-detect latency: 3 `clk` cycles from a synchronous `tick_in` rise to `edge`. Both edges are delayed equally, so the measured period is exact.
- Strobes N cycles apart give `period` = N; the minimum measurable period is 2.
- `period_valid` rises 1 cycle after the `edge` cycle, i.e. 4 cycles after the second `tick_in` rise.
- Timeout pulse: `timeout` is high in the cycle after `cnt` == TIMEOUT is seen without an edge. That is TIMEOUT+1 cycles after the last edge cycle.
- The output register is a single holding stage. Full throughput (one result per period) needs `period_ready` high at least once per period.

## Structure
- Package `period_meter_pkg`:
  - state enum `meter_state_t` {IDLE, MEASURE};
  - `SYNC_STAGES` = 2 constant.
- Sub-module `sync_edge`: synchronizer plus rising-edge detect. Parameter: stage count. Output: one-cycle `edge` pulse.
- The top level holds the FSM, counter, result register and flags.

## Test plan
- 1-cycle strobe every 5 cycles, `period_ready` = 1 -> `period` = 5 on every measurement after the first edge; `overrun` = 0.
- `tick_in` high for 3 cycles every 10 cycles -> `period` = 10, one edge per pulse.
- TIMEOUT = 8, strobe at t = 0 then none -> one `timeout` pulse, `active` falls, no `period_valid`. Next strobe re-enters MEASURE.
- TIMEOUT = 8, strobes exactly 8 cycles apart -> `period` = 8, no `timeout`.
- `period_ready` = 0, strobes every 4 cycles -> first `period` = 4 held. `overrun` sets at the second capture. Value is unchanged until ready.
- Reset asserted mid-MEASURE with `period_valid` high -> all outputs 0 immediately. Measurement restarts from IDLE after release.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the strobe period meter.
package period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Synchronizer chain plus registered rising-edge detect for an async strobe.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_pulse
);

  logic [STAGES-1:0] sync;
  logic              s_prev;

  // Registering the edge keeps the strobe-to-edge latency a fixed 3 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      s_prev     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[STAGES-2:0], din};
      s_prev     <= sync[STAGES-1];
      edge_pulse <= sync[STAGES-1] & ~s_prev;
    end
  end

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between strobe rising edges; one-deep valid/ready result
// with timeout pulse and sticky overrun flag.
module period_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun,
  output logic             active
);
  import period_meter_pkg::*;

  localparam logic [WIDTH-1:0] TMAX = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  meter_state_t     state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             edge_pulse;
  logic             capture;
  logic             timeout_n;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .din        (tick_in),
    .edge_pulse (edge_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // An edge on the terminal count still closes the period, so cnt never wraps.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (edge_pulse) begin
          state_n = MEASURE;
          cnt_n   = ONE;
        end
      end
      MEASURE: begin
        if (edge_pulse) begin
          capture = 1'b1;
          cnt_n   = ONE;
        end else if (cnt == TMAX) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      timeout <= timeout_n;
      if (capture) begin
        if (!period_valid || period_ready) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (period_ready) begin
        period_valid <= 1'b0;
      end
    end
  end

  assign active = (state == MEASURE);

endmodule
